// File: rtl/sfq_chk_pkg.sv
// Shared types and defaults for the SFQ clocked-AND response checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sfq_chk_pkg;

   // Checker FSM: collecting inputs, or waiting for q after a gate clock.
   typedef enum logic [0:0] {
      ACCUM  = 1'b0,
      WAIT_Q = 1'b1
   } chk_state_t;

   // Per-window verdict.
   typedef enum logic [1:0] {
      V_OK       = 2'd0,
      V_MISSING  = 2'd1,
      V_SPURIOUS = 2'd2
   } verdict_t;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int Q_TIMEOUT_DEF   = 8;
   localparam int CNT_W_DEF       = 16;

endpackage

// File: rtl/sfq_tgl_decode.sv
// Converts a toggle-encoded pulse wire into a 1-cycle pulse on clk.
// Latency: SYNC_STAGES+1 cycles from toggle to registered pulse.
// Backpressure: none; every toggle yields exactly one pulse.
module sfq_tgl_decode #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic tgl,
   output logic pulse
);

   logic synced;
   logic prev;

   generate
      if (SYNC_STAGES == 0) begin : g_direct
         assign synced = tgl;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] chain;

         // Metastability chain; left free-running through reset so the
         // history load below sees a settled level.
         always_ff @(posedge clk) begin
            chain[0] <= tgl;
            for (int i = 1; i < SYNC_STAGES; i++) begin
               chain[i] <= chain[i-1];
            end
         end

         assign synced = chain[SYNC_STAGES-1];
      end
   endgenerate

   // Edge detect: history tracks the synced level, also during reset, so a
   // level left high across reset does not read as a pulse on release.
   always_ff @(posedge clk) begin
      prev <= synced;
      if (rst) begin
         pulse <= 1'b0;
      end else begin
         pulse <= synced ^ prev;
      end
   end

endmodule

// File: rtl/sfq_and_resp_checker.sv
// Checks a toggle-encoded SFQ clocked-AND gate: one verdict per gate-clock window.
// Latency: verdict registered 1 cycle after the deciding decoded pulse (decode adds SYNC_STAGES+1).
// Backpressure: none; passive observer, verdicts are 1-cycle strobes that cannot be stalled.
module sfq_and_resp_checker
   import sfq_chk_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int Q_TIMEOUT   = Q_TIMEOUT_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_tgl,
   input  logic             b_tgl,
   input  logic             sclk_tgl,
   input  logic             q_tgl,
   output logic             res_valid,
   output logic             res_ok,
   output logic             err_missing,
   output logic             err_spurious,
   output logic             dup_input,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             busy
);

   localparam int TMR_W = (Q_TIMEOUT < 1) ? 1 : $clog2(Q_TIMEOUT + 1);

   logic a_p;
   logic b_p;
   logic s_p;
   logic q_p;

   sfq_tgl_decode #(.SYNC_STAGES(SYNC_STAGES)) u_dec_a (
      .clk   (clk),
      .rst   (rst),
      .tgl   (a_tgl),
      .pulse (a_p)
   );

   sfq_tgl_decode #(.SYNC_STAGES(SYNC_STAGES)) u_dec_b (
      .clk   (clk),
      .rst   (rst),
      .tgl   (b_tgl),
      .pulse (b_p)
   );

   sfq_tgl_decode #(.SYNC_STAGES(SYNC_STAGES)) u_dec_sclk (
      .clk   (clk),
      .rst   (rst),
      .tgl   (sclk_tgl),
      .pulse (s_p)
   );

   sfq_tgl_decode #(.SYNC_STAGES(SYNC_STAGES)) u_dec_q (
      .clk   (clk),
      .rst   (rst),
      .tgl   (q_tgl),
      .pulse (q_p)
   );

   chk_state_t       state;
   chk_state_t       state_n;
   logic             a_seen;
   logic             a_seen_n;
   logic             b_seen;
   logic             b_seen_n;
   logic             exp_q;
   logic             exp_n;
   logic [TMR_W-1:0] tmr;
   logic [TMR_W-1:0] tmr_n;
   logic             dup_n;
   logic             vld_n;
   verdict_t         verd_n;
   logic             open_win;

   // Next-state: verdict for the pending window first, then open a new
   // window on a gate clock (inputs in that cycle belong to the new window).
   always_comb begin
      state_n  = state;
      a_seen_n = a_seen;
      b_seen_n = b_seen;
      exp_n    = exp_q;
      tmr_n    = tmr;
      dup_n    = dup_input;
      vld_n    = 1'b0;
      verd_n   = V_OK;
      open_win = 1'b0;

      case (state)
         ACCUM: begin
            // No window pending: any q pulse is unexplained.
            if (q_p) begin
               vld_n  = 1'b1;
               verd_n = V_SPURIOUS;
            end
            if (s_p) begin
               open_win = 1'b1;
            end
         end
         WAIT_Q: begin
            if (q_p) begin
               // q wins over timeout and over a coincident gate clock.
               vld_n   = 1'b1;
               verd_n  = exp_q ? V_OK : V_SPURIOUS;
               state_n = ACCUM;
            end else if (s_p || (tmr == '0)) begin
               // Window closed without q: timeout verdict.
               vld_n   = 1'b1;
               verd_n  = exp_q ? V_MISSING : V_OK;
               state_n = ACCUM;
            end else begin
               tmr_n = tmr - TMR_W'(1);
            end
            if (s_p) begin
               open_win = 1'b1;
            end
         end
         default: begin
            state_n = ACCUM;
         end
      endcase

      if (open_win) begin
         exp_n    = a_seen & b_seen;
         a_seen_n = a_p;
         b_seen_n = b_p;
         tmr_n    = TMR_W'(Q_TIMEOUT);
         state_n  = WAIT_Q;
      end else begin
         if ((a_p && a_seen) || (b_p && b_seen)) begin
            dup_n = 1'b1;
         end
         a_seen_n = a_seen | a_p;
         b_seen_n = b_seen | b_p;
      end
   end

   // FSM, window state and sticky duplicate flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCUM;
         a_seen    <= 1'b0;
         b_seen    <= 1'b0;
         exp_q     <= 1'b0;
         tmr       <= '0;
         dup_input <= 1'b0;
      end else begin
         state     <= state_n;
         a_seen    <= a_seen_n;
         b_seen    <= b_seen_n;
         exp_q     <= exp_n;
         tmr       <= tmr_n;
         dup_input <= dup_n;
      end
   end

   // Registered verdict strobe; flags are zero whenever the strobe is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid    <= 1'b0;
         res_ok       <= 1'b0;
         err_missing  <= 1'b0;
         err_spurious <= 1'b0;
      end else begin
         res_valid    <= vld_n;
         res_ok       <= vld_n && (verd_n == V_OK);
         err_missing  <= vld_n && (verd_n == V_MISSING);
         err_spurious <= vld_n && (verd_n == V_SPURIOUS);
      end
   end

   // Saturating pass/error counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         pass_cnt <= '0;
         err_cnt  <= '0;
      end else if (vld_n) begin
         if (verd_n == V_OK) begin
            if (pass_cnt != '1) begin
               pass_cnt <= pass_cnt + CNT_W'(1);
            end
         end else begin
            if (err_cnt != '1) begin
               err_cnt <= err_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign busy = (state == WAIT_Q);

endmodule

// File: tb/tb_sfq_and_resp_checker.sv
module tb_sfq_and_resp_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic a_tgl;
   logic b_tgl;
   logic sclk_tgl;
   logic q_tgl;

   logic        res_valid, res_ok, err_missing, err_spurious, dup_input, busy;
   logic [15:0] pass_cnt, err_cnt;

   logic        s_res_valid, s_res_ok, s_err_missing, s_err_spurious, s_dup_input, s_busy;
   logic [1:0]  s_pass_cnt, s_err_cnt;

   sfq_and_resp_checker #(.SYNC_STAGES(2), .Q_TIMEOUT(8), .CNT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .a_tgl        (a_tgl),
      .b_tgl        (b_tgl),
      .sclk_tgl     (sclk_tgl),
      .q_tgl        (q_tgl),
      .res_valid    (res_valid),
      .res_ok       (res_ok),
      .err_missing  (err_missing),
      .err_spurious (err_spurious),
      .dup_input    (dup_input),
      .pass_cnt     (pass_cnt),
      .err_cnt      (err_cnt),
      .busy         (busy)
   );

   // Narrow-counter, unsynchronised instance for the saturation corner.
   sfq_and_resp_checker #(.SYNC_STAGES(0), .Q_TIMEOUT(8), .CNT_W(2)) dut_sat (
      .clk          (clk),
      .rst          (rst),
      .a_tgl        (a_tgl),
      .b_tgl        (b_tgl),
      .sclk_tgl     (sclk_tgl),
      .q_tgl        (q_tgl),
      .res_valid    (s_res_valid),
      .res_ok       (s_res_ok),
      .err_missing  (s_err_missing),
      .err_spurious (s_err_spurious),
      .dup_input    (s_dup_input),
      .pass_cnt     (s_pass_cnt),
      .err_cnt      (s_err_cnt),
      .busy         (s_busy)
   );

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   int ev_code[$];
   int ev_cyc[$];
   int s_ok_n, s_miss_n, s_spur_n;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Verdict monitor: one-hot with the strobe, silent otherwise.
   always @(negedge clk) begin
      if (!rst) begin
         if (res_valid) begin
            chk("verdict_onehot", int'(res_ok) + int'(err_missing) + int'(err_spurious), 1);
            ev_code.push_back(res_ok ? 0 : err_missing ? 1 : err_spurious ? 2 : 3);
            ev_cyc.push_back(cyc);
         end else begin
            chk("flags_idle", int'({res_ok, err_missing, err_spurious}), 0);
         end
         if (s_res_valid) begin
            if (s_res_ok) s_ok_n++;
            if (s_err_missing) s_miss_n++;
            if (s_err_spurious) s_spur_n++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ev_code.delete();
      ev_cyc.delete();
      tick(4);
      rst = 1'b0;
      tick(1);
   endtask

   typedef struct {
      string name;
      int    a_n;
      int    b_n;
      int    q_dly;    // cycles after sclk toggle to toggle q, -1 = never
      int    exp_code; // 0 ok, 1 missing, 2 spurious
      int    exp_lat;  // cycles from sclk toggle to res_valid
      int    exp_pass;
      int    exp_err;
      int    exp_dup;
   } vec_t;

   vec_t vecs[7];
   int   start;
   int   start2;

   initial begin
      a_tgl = 1'b0; b_tgl = 1'b0; sclk_tgl = 1'b0; q_tgl = 1'b0;
      rst = 1'b1;
      tick(2);

      // Decode 2 stages + pulse reg + FSM = 4; timeout path adds Q_TIMEOUT+1.
      vecs[0] = '{"ab_q",           1, 1,  3, 0,  7, 1, 0, 0};
      vecs[1] = '{"a_only_timeout", 1, 0, -1, 0, 13, 1, 0, 0};
      vecs[2] = '{"ab_missing",     1, 1, -1, 1, 13, 0, 1, 0};
      vecs[3] = '{"q_not_expected", 0, 0,  2, 2,  6, 0, 1, 0};
      vecs[4] = '{"dup_a",          2, 1,  3, 0,  7, 1, 0, 1};
      vecs[5] = '{"b_only_timeout", 0, 1, -1, 0, 13, 1, 0, 0};
      vecs[6] = '{"q_last_cycle",   1, 1,  9, 0, 13, 1, 0, 0};

      do_reset();
      chk("rst_res_valid",    int'(res_valid),    0);
      chk("rst_res_ok",       int'(res_ok),       0);
      chk("rst_err_missing",  int'(err_missing),  0);
      chk("rst_err_spurious", int'(err_spurious), 0);
      chk("rst_dup_input",    int'(dup_input),    0);
      chk("rst_pass_cnt",     int'(pass_cnt),     0);
      chk("rst_err_cnt",      int'(err_cnt),      0);
      chk("rst_busy",         int'(busy),         0);

      for (int v = 0; v < 7; v++) begin
         do_reset();
         for (int i = 0; i < vecs[v].a_n; i++) begin a_tgl = ~a_tgl; tick(2); end
         for (int i = 0; i < vecs[v].b_n; i++) begin b_tgl = ~b_tgl; tick(2); end
         tick(2);
         sclk_tgl = ~sclk_tgl;
         start = cyc;
         for (int k = 1; k <= 30; k++) begin
            tick(1);
            if (k == vecs[v].q_dly) q_tgl = ~q_tgl;
         end
         chk({vecs[v].name, "_n_verdicts"}, ev_code.size(), 1);
         if (ev_code.size() > 0) begin
            chk({vecs[v].name, "_verdict"}, ev_code[0], vecs[v].exp_code);
            chk({vecs[v].name, "_latency"}, ev_cyc[0] - start, vecs[v].exp_lat);
         end
         chk({vecs[v].name, "_pass_cnt"}, int'(pass_cnt), vecs[v].exp_pass);
         chk({vecs[v].name, "_err_cnt"},  int'(err_cnt),  vecs[v].exp_err);
         chk({vecs[v].name, "_dup"},      int'(dup_input), vecs[v].exp_dup);
         chk({vecs[v].name, "_busy_end"}, int'(busy), 0);
      end

      // q in ACCUM is spurious; duplicate a is sticky until reset.
      do_reset();
      q_tgl = ~q_tgl;
      start = cyc;
      tick(8);
      chk("accq_n_verdicts", ev_code.size(), 1);
      if (ev_code.size() > 0) begin
         chk("accq_verdict", ev_code[0], 2);
         chk("accq_latency", ev_cyc[0] - start, 4);
      end
      chk("accq_err_cnt", int'(err_cnt), 1);
      a_tgl = ~a_tgl; tick(2); a_tgl = ~a_tgl; tick(6);
      chk("dup_set", int'(dup_input), 1);
      sclk_tgl = ~sclk_tgl;
      tick(20);
      chk("dup_held", int'(dup_input), 1);
      chk("dup_win_pass", int'(pass_cnt), 1);
      do_reset();
      chk("dup_cleared", int'(dup_input), 0);

      // Second sclk closes window 1 as missing, window 2 (exp=0) times out ok.
      do_reset();
      a_tgl = ~a_tgl; tick(2); b_tgl = ~b_tgl; tick(4);
      sclk_tgl = ~sclk_tgl;
      start = cyc;
      tick(2);
      sclk_tgl = ~sclk_tgl;
      tick(5);
      chk("dbl_busy", int'(busy), 1);
      tick(20);
      chk("dbl_n_verdicts", ev_code.size(), 2);
      if (ev_code.size() == 2) begin
         chk("dbl_v1", ev_code[0], 1);
         chk("dbl_lat1", ev_cyc[0] - start, 6);
         chk("dbl_v2", ev_code[1], 0);
         chk("dbl_lat2", ev_cyc[1] - start, 15);
      end
      chk("dbl_pass", int'(pass_cnt), 1);
      chk("dbl_err", int'(err_cnt), 1);

      // b coincident with sclk belongs to the next window.
      do_reset();
      a_tgl = ~a_tgl; tick(4);
      b_tgl = ~b_tgl; sclk_tgl = ~sclk_tgl;
      start = cyc;
      tick(20);
      a_tgl = ~a_tgl; tick(4);
      sclk_tgl = ~sclk_tgl;
      start2 = cyc;
      tick(3);
      q_tgl = ~q_tgl;
      tick(10);
      chk("setup_n_verdicts", ev_code.size(), 2);
      if (ev_code.size() == 2) begin
         chk("setup_v1", ev_code[0], 0);
         chk("setup_lat1", ev_cyc[0] - start, 13);
         chk("setup_v2", ev_code[1], 0);
         chk("setup_lat2", ev_cyc[1] - start2, 7);
      end
      chk("setup_pass", int'(pass_cnt), 2);
      chk("setup_err", int'(err_cnt), 0);

      // q and sclk in the same WAIT_Q cycle: q credited to pending window.
      do_reset();
      a_tgl = ~a_tgl; tick(2); b_tgl = ~b_tgl; tick(4);
      sclk_tgl = ~sclk_tgl;
      start = cyc;
      tick(3);
      q_tgl = ~q_tgl; sclk_tgl = ~sclk_tgl;
      tick(25);
      chk("qs_n_verdicts", ev_code.size(), 2);
      if (ev_code.size() == 2) begin
         chk("qs_v1", ev_code[0], 0);
         chk("qs_lat1", ev_cyc[0] - start, 7);
         chk("qs_v2", ev_code[1], 0);
         chk("qs_lat2", ev_cyc[1] - start, 16);
      end
      chk("qs_pass", int'(pass_cnt), 2);

      // Reset mid-WAIT_Q discards the pending verdict.
      do_reset();
      a_tgl = ~a_tgl; tick(2); b_tgl = ~b_tgl; tick(4);
      sclk_tgl = ~sclk_tgl;
      tick(7);
      chk("rstmid_busy", int'(busy), 1);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(20);
      chk("rstmid_n_verdicts", ev_code.size(), 0);
      chk("rstmid_busy_after", int'(busy), 0);
      chk("rstmid_err", int'(err_cnt), 0);
      chk("rstmid_pass", int'(pass_cnt), 0);

      // Saturation: five spurious q; 2-bit counter stops at 3.
      do_reset();
      s_ok_n = 0; s_miss_n = 0; s_spur_n = 0;
      for (int i = 0; i < 5; i++) begin
         q_tgl = ~q_tgl;
         tick(6);
      end
      tick(4);
      chk("sat_main_err", int'(err_cnt), 5);
      chk("sat_main_n_verdicts", ev_code.size(), 5);
      chk("sat_err_cnt", int'(s_err_cnt), 3);
      chk("sat_pass_cnt", int'(s_pass_cnt), 0);
      chk("sat_spurious_n", s_spur_n, 5);
      chk("sat_ok_n", s_ok_n + s_miss_n, 0);
      chk("sat_dup", int'(s_dup_input), 0);
      chk("sat_busy", int'(s_busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
